multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle decode controller.
- Sequences each instruction over several states: fetch, decode, execute, memory, writeback.
- Shares one ALU and one unified memory port per instruction, and stalls on a memory ready handshake.
- Sits between the IR/datapath and the unified memory; drives all datapath mux selects and write enables from one registered FSM.

Parameters:
- ALUCTL_W, 3: width of alu_ctl. Codes: 1=OR, 2=ADD, 3=SUB, 4=SLL, 6=SLTU. Upper bits are zero when ALUCTL_W>3.
- RESET_STATE, 0: state encoding loaded on reset (S_FETCH). Any other value is illegal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26]. Stable from the cycle after ir_write until the next ir_write.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, combinational, same cycle.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, qualified by mem_req.
- iord  out  1  address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR.
- pc_en  out  1  PC load enable.
- pc_src  out  2  PC source: 0=ALU result, 1=ALUOut (branch target), 2=rs (jr), 3=jump target.
- alu_a_src  out  2  ALU A: 0=PC, 1=rs, 2=shamt.
- alu_b_src  out  3  ALU B: 0=rt, 1=const 4, 2=sign-ext imm, 3=zero-ext imm, 4=sign-ext imm<<2.
- alu_ctl  out  ALUCTL_W  ALU operation.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  destination: 0=rt, 1=rd, 2=$31.
- mem_to_reg  out  2  writeback data: 0=ALUOut, 1=MDR, 2=imm<<16, 3=PC.
- busy  out  1  high in every state except S_FETCH.

Behaviour:
- Async reset (rst_n=0): state=S_FETCH. Registered outputs go to 0 immediately and stay 0 while reset is held.
- Outputs are decoded from the registered state, op and funct. The only combinational input paths are zero (into pc_en) and mem_ready (into ir_write/pc_en).
- Every output not listed for a state is 0.
- S_FETCH:
  - mem_req=1, iord=0, alu_a_src=0, alu_b_src=1, alu_ctl=2.
  - If mem_ready=1: ir_write=1, pc_en=1, pc_src=0, next state S_DECODE.
  - Otherwise hold S_FETCH with ir_write=pc_en=0.
- S_DECODE: alu_a_src=0, alu_b_src=4, alu_ctl=2 (branch target into ALUOut). Next state by op:
  - 100011 (lw) / 101011 (sw) -> S_MADDR
  - 000000 funct 100001 (addu) / 100011 (subu) / 000000 (sll) -> S_REXE
  - 000000 funct 001000 (jr) -> S_JR
  - 001101 (ori) / 001011 (sltiu) -> S_IEXE
  - 000100 (beq) -> S_BEQ
  - 001111 (lui) -> S_LUI
  - 000011 (jal) -> S_JAL
  - 000010 (j) -> S_J
  - any other op, or an unlisted funct under op 000000 -> S_FETCH (no-op)
- S_MADDR: alu_a_src=1, alu_b_src=2, alu_ctl=2. Next S_MRD (lw) or S_MWR (sw).
- S_MRD: mem_req=1, iord=1. On mem_ready -> S_MWB, else hold.
- S_MWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> S_FETCH.
- S_MWR: mem_req=1, mem_we=1, iord=1. On mem_ready -> S_FETCH, else hold. mem_we stays high for every held cycle.
- S_REXE: alu_a_src=1 (2 for sll), alu_b_src=0, alu_ctl=2/3/4 for addu/subu/sll -> S_RWB.
- S_RWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> S_FETCH.
- S_IEXE: alu_a_src=1. ori: alu_b_src=3, alu_ctl=1. sltiu: alu_b_src=2, alu_ctl=6. -> S_IWB.
- S_IWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> S_FETCH.
- S_BEQ: alu_a_src=1, alu_b_src=0, alu_ctl=3, pc_src=1, pc_en=zero -> S_FETCH.
- S_LUI: reg_write=1, reg_dst=0, mem_to_reg=2 -> S_FETCH.
- S_JAL: reg_write=1, reg_dst=2, mem_to_reg=3, pc_en=1, pc_src=3 -> S_FETCH. PC already holds PC+4.
- S_J: pc_en=1, pc_src=3 -> S_FETCH.
- S_JR: pc_en=1, pc_src=2 -> S_FETCH.
- Latency with zero wait states, in cycles: lw 5; sw, R-type, ori, sltiu 4; beq, j, jal, jr, lui 3. Each memory wait cycle adds 1.
- Reset mid-instruction: the instruction is abandoned, no partial writeback occurs, and execution restarts at S_FETCH.
- mem_ready outside S_FETCH, S_MRD and S_MWR is ignored.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- When defined:
  - Undecoded op/funct in S_DECODE goes to S_TRAP.
  - S_TRAP drives pc_en=1, pc_src=3 and adds output trap (1 bit), high for exactly that one cycle, then S_FETCH. The datapath muxes the vector in when trap=1.
  - reg_write stays 0 in S_TRAP.
- When undefined: no trap port, no S_TRAP; undecoded instructions return silently to S_FETCH as a no-op.

Test Plan:
- Reset: rst_n=0 asynchronously mid-S_MRD -> all outputs 0 within the same cycle; after release, first cycle is S_FETCH with mem_req=1.
- lw with mem_ready low 2 cycles in S_FETCH and 1 cycle in S_MRD -> 8 cycles total; reg_write=1, mem_to_reg=1 only in the final cycle.
- addu (op 0, funct 100001), ready always 1 -> 4 cycles; S_REXE alu_ctl=2; S_RWB reg_write=1, reg_dst=1.
- beq with zero=1, then with zero=0 -> pc_en=1 / pc_en=0 in the 3rd cycle, pc_src=1 in both cases.
- jal -> 3rd cycle has reg_write=1, reg_dst=2, mem_to_reg=3, pc_en=1, pc_src=3.
- op 111111:
  - Macro undefined -> back to S_FETCH after decode, no writes.
  - Macro defined -> trap=1 for one cycle with pc_en=1, pc_src=3.

Source files
------------

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//
// Purpose: sequences each instruction through fetch / decode / execute /
// memory / writeback. It shares one ALU and one unified memory port, and it
// stalls on the memory ready handshake. Every datapath mux select and write
// enable comes from one registered state machine. The outputs are decoded
// from the registered state together with op and funct. The only
// combinational input paths are zero (into pc_en) and mem_ready (into
// ir_write and pc_en).
//
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to send undecoded
// instructions to a one-cycle trap state. That state loads the vector through
// pc_src=3 and raises the extra output 'trap'. Without the macro, undecoded
// instructions retire silently as a no-op.
//
// Parameters:
//   ALUCTL_W    width of alu_ctl (codes 1=OR 2=ADD 3=SUB 4=SLL 6=SLTU)
//   RESET_STATE state encoding loaded on reset; only 0 (S_FETCH) is legal
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   op, funct            IR[31:26], IR[5:0]
//   zero                 ALU zero flag (same cycle)
//   mem_ready            memory completed the current access this cycle
//   mem_req, mem_we      unified memory request / write strobe
//   iord                 address select 0=PC 1=ALUOut
//   ir_write             load IR
//   pc_en, pc_src        PC load enable / source (ALU, ALUOut, rs, jump)
//   alu_a_src, alu_b_src ALU operand selects
//   alu_ctl              ALU operation
//   reg_write, reg_dst   register file write enable / destination
//   mem_to_reg           writeback data select
//   busy                 high in every state except S_FETCH
//   trap                 (CTRL_ILLEGAL_TRAP_EN only) illegal-instruction trap
// ----------------------------------------------------------------------------
module multicycle_controller #(
   parameter int ALUCTL_W    = 3,
   parameter int RESET_STATE = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          op,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                iord,
   output logic                ir_write,
   output logic                pc_en,
   output logic [1:0]          pc_src,
   output logic [1:0]          alu_a_src,
   output logic [2:0]          alu_b_src,
   output logic [ALUCTL_W-1:0] alu_ctl,
   output logic                reg_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          mem_to_reg,
   output logic                busy
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,
   output logic                trap
`endif
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MADDR  = 4'd2,
      S_MRD    = 4'd3,
      S_MWB    = 4'd4,
      S_MWR    = 4'd5,
      S_REXE   = 4'd6,
      S_RWB    = 4'd7,
      S_IEXE   = 4'd8,
      S_IWB    = 4'd9,
      S_BEQ    = 4'd10,
      S_LUI    = 4'd11,
      S_JAL    = 4'd12,
      S_J      = 4'd13,
      S_JR     = 4'd14
`ifdef CTRL_ILLEGAL_TRAP_EN
      ,
      S_TRAP   = 4'd15
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [ALUCTL_W-1:0] ALU_OR   = ALUCTL_W'(1);
   localparam logic [ALUCTL_W-1:0] ALU_ADD  = ALUCTL_W'(2);
   localparam logic [ALUCTL_W-1:0] ALU_SUB  = ALUCTL_W'(3);
   localparam logic [ALUCTL_W-1:0] ALU_SLL  = ALUCTL_W'(4);
   localparam logic [ALUCTL_W-1:0] ALU_SLTU = ALUCTL_W'(6);

   // This is the state that an undecoded instruction falls into.
`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam state_t S_ILLEGAL = S_TRAP;
`else
   localparam state_t S_ILLEGAL = S_FETCH;
`endif

   state_t state, state_nxt;

   // Decode dispatch: the IR has been loaded by now, so op/funct are valid.
   function automatic state_t decode_dispatch(input logic [5:0] o, input logic [5:0] f);
      state_t s;
      s = S_ILLEGAL;
      case (o)
         OP_LW, OP_SW:     s = S_MADDR;
         OP_ORI, OP_SLTIU: s = S_IEXE;
         OP_BEQ:           s = S_BEQ;
         OP_LUI:           s = S_LUI;
         OP_JAL:           s = S_JAL;
         OP_J:             s = S_J;
         OP_RTYPE: begin
            case (f)
               FN_ADDU, FN_SUBU, FN_SLL: s = S_REXE;
               FN_JR:                    s = S_JR;
               default:                  s = S_ILLEGAL;
            endcase
         end
         default:          s = S_ILLEGAL;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= state_t'(4'(RESET_STATE));
      else        state <= state_nxt;
   end

   // Everything is forced low while rst_n is held. The abandoned instruction
   // therefore cannot leave a write enable asserted during reset.
   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 2'd0;
      alu_a_src  = 2'd0;
      alu_b_src  = 3'd0;
      alu_ctl    = '0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      busy       = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap       = 1'b0;
`endif
      if (rst_n) begin
         busy = (state != S_FETCH);
         case (state)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_b_src = 3'd1;
               alu_ctl   = ALU_ADD;
               ir_write  = mem_ready;
               pc_en     = mem_ready;
               if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
               // The branch target PC + (imm<<2) is computed here into ALUOut.
               alu_b_src = 3'd4;
               alu_ctl   = ALU_ADD;
               state_nxt = decode_dispatch(op, funct);
            end
            S_MADDR: begin
               alu_a_src = 2'd1;
               alu_b_src = 3'd2;
               alu_ctl   = ALU_ADD;
               state_nxt = (op == OP_LW) ? S_MRD : S_MWR;
            end
            S_MRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               if (mem_ready) state_nxt = S_MWB;
            end
            S_MWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 2'd1;
               state_nxt  = S_FETCH;
            end
            S_MWR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
               if (mem_ready) state_nxt = S_FETCH;
            end
            S_REXE: begin
               alu_a_src = (funct == FN_SLL) ? 2'd2 : 2'd1;
               alu_ctl   = (funct == FN_SLL)  ? ALU_SLL :
                           (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
               state_nxt = S_RWB;
            end
            S_RWB: begin
               reg_write = 1'b1;
               reg_dst   = 2'd1;
               state_nxt = S_FETCH;
            end
            S_IEXE: begin
               alu_a_src = 2'd1;
               alu_b_src = (op == OP_ORI) ? 3'd3 : 3'd2;
               alu_ctl   = (op == OP_ORI) ? ALU_OR : ALU_SLTU;
               state_nxt = S_IWB;
            end
            S_IWB: begin
               reg_write = 1'b1;
               state_nxt = S_FETCH;
            end
            S_BEQ: begin
               alu_a_src = 2'd1;
               alu_ctl   = ALU_SUB;
               pc_src    = 2'd1;
               pc_en     = zero;
               state_nxt = S_FETCH;
            end
            S_LUI: begin
               reg_write  = 1'b1;
               mem_to_reg = 2'd2;
               state_nxt  = S_FETCH;
            end
            S_JAL: begin
               // The PC already holds PC+4, so it is the link value for $31.
               reg_write  = 1'b1;
               reg_dst    = 2'd2;
               mem_to_reg = 2'd3;
               pc_en      = 1'b1;
               pc_src     = 2'd3;
               state_nxt  = S_FETCH;
            end
            S_J: begin
               pc_en     = 1'b1;
               pc_src    = 2'd3;
               state_nxt = S_FETCH;
            end
            S_JR: begin
               pc_en     = 1'b1;
               pc_src    = 2'd2;
               state_nxt = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
               trap      = 1'b1;
               pc_en     = 1'b1;
               pc_src    = 2'd3;
               state_nxt = S_FETCH;
            end
`endif
            default: state_nxt = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. For each instruction it
// builds the expected per-cycle output sequence from the instruction class.
// It then drives randomized memory wait states and ignored inputs, and
// compares the DUT outputs cycle by cycle. It also checks the reset
// behaviour and the latency counts.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op, funct;
   logic       zero, mem_ready;
   logic       mem_req, mem_we, iord, ir_write, pc_en, reg_write, busy;
   logic [1:0] pc_src, alu_a_src, reg_dst, mem_to_reg;
   logic [2:0] alu_b_src, alu_ctl;
`ifdef CTRL_ILLEGAL_TRAP_EN
   logic       trap;
`endif

   multicycle_controller #(.ALUCTL_W(3), .RESET_STATE(0)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
      .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_ctl(alu_ctl),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .busy(busy)
`ifdef CTRL_ILLEGAL_TRAP_EN
      , .trap(trap)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req, mem_we, iord, ir_write, pc_en;
      logic [1:0] pc_src, alu_a_src;
      logic [2:0] alu_b_src, alu_ctl;
      logic       reg_write;
      logic [1:0] reg_dst, mem_to_reg;
      logic       busy;
   } outs_t;

   outs_t obs;
   assign obs = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_a_src,
                 alu_b_src, alu_ctl, reg_write, reg_dst, mem_to_reg, busy};

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   // Opcode map, taken from the instruction set.
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, ORI = 6'b001101,
                          SLTIU = 6'b001011, BEQ = 6'b000100, LUI = 6'b001111,
                          JAL = 6'b000011, J = 6'b000010, RT = 6'b000000;
   localparam logic [5:0] ADDU = 6'b100001, SUBU = 6'b100011, SLL = 6'b000000,
                          JR = 6'b001000;

   function automatic bit is_legal(input logic [5:0] o, input logic [5:0] f);
      if (o == RT) return (f == ADDU || f == SUBU || f == SLL || f == JR);
      return (o == LW || o == SW || o == ORI || o == SLTIU || o == BEQ ||
              o == LUI || o == JAL || o == J);
   endfunction

   // Zero-wait-state latency in cycles, from the instruction timing table.
   function automatic int latency(input logic [5:0] o, input logic [5:0] f);
      if (!is_legal(o, f)) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
         return 3;
`else
         return 2;
`endif
      end
      if (o == LW) return 5;
      if (o == SW || o == ORI || o == SLTIU) return 4;
      if (o == RT && f != JR) return 4;
      return 3;
   endfunction

   function automatic outs_t blank();
      outs_t t;
      t = '0;
      t.busy = 1'b1;
      return t;
   endfunction

   // One instruction: build the expected cycle plan, then walk it.
   // fw / mw: forced wait count for fetch / memory step (-1 = random).
   // abort_at: stop at the first cycle of that step (-1 = run to the end).
   task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int fw, input int mw, input int abort_at);
      outs_t plan[$];
      bit    waitq[$];
      bit    trapq[$];
      outs_t e;
      int    beq_idx = -1;
      int    fetch_cyc = 0, busy_cyc = 0, fwaits = 0, mwaits = 0;
      bit    rdy;

      e = '0; e.mem_req = 1; e.alu_b_src = 1; e.alu_ctl = 2;
      plan.push_back(e); waitq.push_back(1); trapq.push_back(0);
      e = blank(); e.alu_b_src = 4; e.alu_ctl = 2;
      plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
      if (o == LW || o == SW) begin
         e = blank(); e.alu_a_src = 1; e.alu_b_src = 2; e.alu_ctl = 2;
         plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
         e = blank(); e.mem_req = 1; e.iord = 1; e.mem_we = (o == SW);
         plan.push_back(e); waitq.push_back(1); trapq.push_back(0);
         if (o == LW) begin
            e = blank(); e.reg_write = 1; e.mem_to_reg = 1;
            plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
         end
      end else if (is_legal(o, f) && o == RT && f != JR) begin
         e = blank(); e.alu_a_src = (f == SLL) ? 2 : 1;
         e.alu_ctl = (f == ADDU) ? 3'd2 : (f == SUBU) ? 3'd3 : 3'd4;
         plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
         e = blank(); e.reg_write = 1; e.reg_dst = 1;
         plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
      end else if (o == ORI || o == SLTIU) begin
         e = blank(); e.alu_a_src = 1;
         e.alu_b_src = (o == ORI) ? 3'd3 : 3'd2;
         e.alu_ctl   = (o == ORI) ? 3'd1 : 3'd6;
         plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
         e = blank(); e.reg_write = 1;
         plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
      end else if (o == BEQ) begin
         e = blank(); e.alu_a_src = 1; e.alu_ctl = 3; e.pc_src = 1; e.pc_en = z;
         beq_idx = plan.size();
         plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
      end else if (o == LUI) begin
         e = blank(); e.reg_write = 1; e.mem_to_reg = 2;
         plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
      end else if (o == JAL || o == J) begin
         e = blank(); e.pc_en = 1; e.pc_src = 3;
         if (o == JAL) begin e.reg_write = 1; e.reg_dst = 2; e.mem_to_reg = 3; end
         plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
      end else if (o == RT && f == JR) begin
         e = blank(); e.pc_en = 1; e.pc_src = 2;
         plan.push_back(e); waitq.push_back(0); trapq.push_back(0);
      end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
         e = blank(); e.pc_en = 1; e.pc_src = 3;
         plan.push_back(e); waitq.push_back(0); trapq.push_back(1);
`endif
      end

      for (int s = 0; s < plan.size(); s++) begin
         for (int held = 0; held <= 16; held++) begin
            @(negedge clk);
            if (waitq[s]) begin
               if ((s == 0 ? fw : mw) >= 0) rdy = (held >= (s == 0 ? fw : mw));
               else                         rdy = (held >= 8) || ($urandom_range(3) != 0);
            end else begin
               rdy = 1'($urandom_range(1));
            end
            mem_ready = rdy;
            zero = (s == beq_idx) ? z : 1'($urandom_range(1));
            // The IR changes only after the fetch completes.
            if (s > 0) begin op = o; funct = f; end
            #1;
            e = plan[s];
            if (s == 0) begin e.ir_write = rdy; e.pc_en = rdy; end
            chk($sformatf("%s step%0d", tag, s), 32'(obs), 32'(e));
`ifdef CTRL_ILLEGAL_TRAP_EN
            chk($sformatf("%s trap step%0d", tag, s), 32'(trap), 32'(trapq[s]));
`endif
            if (s == abort_at) return;
            if (obs.busy) busy_cyc++; else if (obs.mem_req) fetch_cyc++;
            if (!waitq[s] || rdy) break;
            if (s == 0) fwaits++; else mwaits++;
         end
      end
      chk({tag, " fetch cycles"}, 32'(fetch_cyc), 32'(1 + fwaits));
      chk({tag, " busy cycles"}, 32'(busy_cyc), 32'(latency(o, f) - 1 + mwaits));
   endtask

   initial begin
      logic [5:0] ops[14];
      logic [5:0] fns[14];
      int k;
      ops = '{LW, SW, RT, RT, RT, RT, ORI, SLTIU, BEQ, LUI, JAL, J, 6'b111111, RT};
      fns = '{0, 0, ADDU, SUBU, SLL, JR, 0, 0, 0, 0, 0, 0, 0, 6'b101010};

      rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk("reset outputs", 32'(obs), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("first fetch after reset", 32'(obs), 32'h0_0000 | 32'(outs_t'{1'b1, 1'b0, 1'b0,
             1'b0, 1'b0, 2'd0, 2'd0, 3'd1, 3'd2, 1'b0, 2'd0, 2'd0, 1'b0}));

      // lw: 2 fetch waits + 1 read wait, 8 cycles in total.
      run_instr("lw_wait", LW, 6'd0, 1'b0, 2, 1, -1);
      run_instr("addu", RT, ADDU, 1'b0, 0, 0, -1);
      run_instr("beq_taken", BEQ, 6'd5, 1'b1, 0, 0, -1);
      run_instr("beq_not_taken", BEQ, 6'd9, 1'b0, 0, 0, -1);
      run_instr("jal", JAL, 6'd0, 1'b0, 0, 0, -1);
      run_instr("illegal_op", 6'b111111, 6'd0, 1'b0, 0, 0, -1);
      run_instr("sw_wait", SW, 6'd3, 1'b0, 1, 3, -1);

      // Reset asserted asynchronously mid memory read (with mem_ready low).
      run_instr("lw_abort", LW, 6'd0, 1'b0, 0, 5, 3);
      rst_n = 1'b0;
      #1 chk("async reset mid read", 32'(obs), 32'd0);
      @(posedge clk);
      #1 chk("reset held across edge", 32'(obs), 32'd0);
      @(negedge clk);
      mem_ready = 1'b0;
      rst_n = 1'b1;
      #1 chk("restart in fetch", 32'(obs), 32'(outs_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
             2'd0, 2'd0, 3'd1, 3'd2, 1'b0, 2'd0, 2'd0, 1'b0}));

      for (int i = 0; i < 60; i++) begin
         logic [5:0] fsel;
         k = $urandom_range(13);
         fsel = (ops[k] == RT) ? fns[k] : 6'($urandom);
         run_instr($sformatf("rand%0d", i), ops[k], fsel, 1'($urandom_range(1)), -1, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
